usb_tx: RTL and testbench

USB low-speed (1.5 Mbit/s) packet transmitter: the transmit counterpart of `usb_rx`. It takes bytes from the USB controller over a valid/ready handshake, prepends SYNC, bit-stuffs, NRZI-encodes and appends EOP. It drives D+/D- (`d_port_t`) plus an output enable for the GPIO pad drivers. It runs on the system clock, advancing one bit per bit-rate clock enable.

---
 rtl/usb_tx.sv | 169 ++++++++++++++++
 tb/tb_usb_tx.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx.sv
// usb_tx: USB low-speed packet transmitter (SYNC, bit stuffing, NRZI, EOP).
// Ports: clk, reset (async, high), clk_en bit strobe, data/valid/last/ready
// byte handshake, txd {D+,D-}, oe pad enable, active, error (underrun).
package usb_tx_pkg;
  typedef logic [1:0] d_port_t;
  localparam d_port_t LINE_J   = 2'b01;
  localparam d_port_t LINE_K   = 2'b10;
  localparam d_port_t LINE_SE0 = 2'b00;
endpackage

import usb_tx_pkg::*;

module usb_tx (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_en,
  input  logic [7:0] data,
  input  logic       valid,
  input  logic       last,
  output logic       ready,
  output d_port_t    txd,
  output logic       oe,
  output logic       active,
  output logic       error
);

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    DATA,
    EOP
  } state_t;

  state_t     state, state_n;
  logic [7:0] shift, shift_n;
  logic       last_q, last_n;
  logic [2:0] cnt, cnt_n;
  logic [2:0] ones, ones_n;
  logic       fin, fin_n;
  d_port_t    txd_n;
  logic       oe_n, active_n;
  d_port_t    tog;
  logic       stuff;

  assign tog   = (txd == LINE_J) ? LINE_K : LINE_J;
  assign stuff = (ones == 3'd6);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      shift  <= '0;
      last_q <= 1'b0;
      cnt    <= '0;
      ones   <= '0;
      fin    <= 1'b0;
      txd    <= LINE_J;
      oe     <= 1'b0;
      active <= 1'b0;
    end else begin
      state  <= state_n;
      shift  <= shift_n;
      last_q <= last_n;
      cnt    <= cnt_n;
      ones   <= ones_n;
      fin    <= fin_n;
      txd    <= txd_n;
      oe     <= oe_n;
      active <= active_n;
    end
  end

  always_comb begin
    state_n  = state;
    shift_n  = shift;
    last_n   = last_q;
    cnt_n    = cnt;
    ones_n   = ones;
    fin_n    = fin;
    txd_n    = txd;
    oe_n     = oe;
    active_n = active;
    ready    = 1'b0;
    error    = 1'b0;
    if (clk_en) begin
      unique case (state)
        IDLE: begin
          ready = 1'b1;
          if (valid) begin
            shift_n  = data;
            last_n   = last;
            cnt_n    = 3'd1;
            ones_n   = '0;
            fin_n    = 1'b0;
            txd_n    = LINE_K;
            oe_n     = 1'b1;
            active_n = 1'b1;
            state_n  = SYNC;
          end
        end
        SYNC: begin
          // cnt counts SYNC bits already on the line; the
          // eighth bit is the single 1 of the pattern.
          if (cnt == 3'd7) begin
            ones_n  = 3'd1;
            cnt_n   = '0;
            state_n = DATA;
          end else begin
            txd_n = tog;
            cnt_n = cnt + 3'd1;
          end
        end
        DATA: begin
          if (stuff) begin
            txd_n  = tog;
            ones_n = '0;
            if (fin) begin
              fin_n   = 1'b0;
              cnt_n   = '0;
              state_n = EOP;
            end
          end else begin
            txd_n   = shift[0] ? txd : tog;
            ones_n  = shift[0] ? ones + 3'd1 : '0;
            shift_n = shift >> 1;
            cnt_n   = cnt + 3'd1;
            if (cnt == 3'd7) begin
              if (last_q) begin
                // a sixth one on the final bit still owes a stuff bit
                if (shift[0] && ones == 3'd5) begin
                  fin_n = 1'b1;
                end else begin
                  cnt_n   = '0;
                  state_n = EOP;
                end
              end else begin
                ready = 1'b1;
                if (valid) begin
                  shift_n = data;
                  last_n  = last;
                end else begin
                  error   = 1'b1;
                  cnt_n   = '0;
                  state_n = EOP;
                end
              end
            end
          end
        end
        EOP: begin
          cnt_n = cnt + 3'd1;
          unique case (1'b1)
            (cnt == 3'd0),
            (cnt == 3'd1): txd_n = LINE_SE0;
            (cnt == 3'd2): txd_n = LINE_J;
            default: begin
              txd_n    = LINE_J;
              oe_n     = 1'b0;
              active_n = 1'b0;
              cnt_n    = '0;
              state_n  = IDLE;
            end
          endcase
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx.sv
// tb_usb_tx: randomized scoreboard bench for usb_tx.
// Line symbols are predicted from the byte stream and compared per bit time.
module tb_usb_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clk_en = 1'b0;
  logic [7:0] data = '0;
  logic       valid = 1'b0;
  logic       last = 1'b0;
  logic       ready;
  logic [1:0] txd;
  logic       oe;
  logic       active;
  logic       error;

  usb_tx dut (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .data   (data),
    .valid  (valid),
    .last   (last),
    .ready  (ready),
    .txd    (txd),
    .oe     (oe),
    .active (active),
    .error  (error)
  );

  always #5 clk = ~clk;

  int div = 0;
  always @(posedge clk) begin
    div    <= (div == 15) ? 0 : div + 1;
    clk_en <= (div == 15);
  end

  typedef struct packed {
    logic [1:0] txd;
    logic       oe;
  } sym_t;

  sym_t       exp_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         hs_cnt = 0;
  int         err_cnt = 0;
  int         exp_hs = 0;
  int         exp_err = 0;
  bit         in_pkt = 0;
  logic [1:0] prev_txd = 2'b01;
  logic       prev_oe = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Reference: logical bit list (SYNC, data, stuffed zeros) then NRZI.
  task automatic push_pkt(input logic [7:0] b[$], input bit trunc);
    bit         bits[$];
    int         ones;
    logic [1:0] lvl;
    sym_t       s;
    for (int i = 0; i < 7; i++) bits.push_back(1'b0);
    bits.push_back(1'b1);
    ones = 1;
    foreach (b[i]) begin
      for (int j = 0; j < 8; j++) begin
        bits.push_back(b[i][j]);
        ones = b[i][j] ? ones + 1 : 0;
        if (ones == 6 && !(trunc && i == b.size() - 1 && j == 7)) begin
          bits.push_back(1'b0);
          ones = 0;
        end
      end
    end
    lvl = 2'b01;
    foreach (bits[k]) begin
      if (!bits[k]) lvl = (lvl == 2'b01) ? 2'b10 : 2'b01;
      s.txd = lvl;
      s.oe  = 1'b1;
      exp_q.push_back(s);
    end
    s = '{txd: 2'b00, oe: 1'b1}; exp_q.push_back(s);
    s = '{txd: 2'b00, oe: 1'b1}; exp_q.push_back(s);
    s = '{txd: 2'b01, oe: 1'b1}; exp_q.push_back(s);
    s = '{txd: 2'b01, oe: 1'b0}; exp_q.push_back(s);
  endtask

  task automatic wait_hs();
    int t;
    bit ok;
    t  = 0;
    ok = 0;
    while (t < 4000) begin
      @(negedge clk);
      if (ready && !reset) begin
        ok = 1;
        break;
      end
      t++;
    end
    @(posedge clk);
    #1;
    if (!ok) fail_now("handshake_timeout");
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || in_pkt) && t < 5000) begin
      @(posedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    if (t >= 5000) fail_now("drain_timeout");
  endtask

  task automatic send_pkt(input logic [7:0] b[$], input bit trunc);
    push_pkt(b, trunc);
    exp_hs += b.size();
    if (trunc) exp_err++;
    foreach (b[i]) begin
      data  = b[i];
      last  = !trunc && (i == b.size() - 1);
      valid = 1'b1;
      wait_hs();
    end
    valid = 1'b0;
    last  = 1'b0;
    if (trunc) drain();
  endtask

  // Line monitor: one expected symbol per bit time while a packet is up.
  always @(posedge clk) begin
    logic en_s;
    logic rst_s;
    sym_t e;
    en_s  = clk_en;
    rst_s = reset;
    #1;
    if (rst_s) begin
      exp_q.delete();
      in_pkt = 0;
    end else if (en_s) begin
      if (oe || in_pkt) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_tx");
        end else begin
          e = exp_q.pop_front();
          chk("txd", 32'(txd), 32'(e.txd));
          chk("oe", 32'(oe), 32'(e.oe));
          chk("active", 32'(active), 32'(e.oe));
          in_pkt = e.oe;
        end
      end else begin
        chk("idle_txd", 32'(txd), 32'h1);
        chk("idle_active", 32'(active), 32'h0);
      end
    end else begin
      chk("hold_txd", 32'(txd), 32'(prev_txd));
      chk("hold_oe", 32'(oe), 32'(prev_oe));
    end
    prev_txd = txd;
    prev_oe  = oe;
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (ready && valid) hs_cnt++;
      if (error) begin
        err_cnt++;
        chk("error_qual", 32'({ready, valid}), 32'h2);
      end
      if (!clk_en) chk("ready_gated", 32'(ready), 32'h0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b[$];
    int         n;
    bit         trunc;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_txd", 32'(txd), 32'h1);
    chk("rst_oe", 32'(oe), 32'h0);
    chk("rst_active", 32'(active), 32'h0);
    chk("rst_error", 32'(error), 32'h0);
    chk("rst_ready", 32'(ready), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    b = '{8'h00}; send_pkt(b, 0); drain();
    b = '{8'hFF}; send_pkt(b, 0); drain();
    b = '{8'hFC}; send_pkt(b, 0); drain();
    b = '{8'h2D, 8'hA5, 8'h5A}; send_pkt(b, 0); drain();
    b = '{8'h01}; send_pkt(b, 1);
    b = '{8'h00}; send_pkt(b, 0); drain();

    // reset during the second byte of a three-byte packet
    b = '{8'h11, 8'h22, 8'h33};
    push_pkt(b, 0);
    exp_hs += 2;
    data  = 8'h11;
    valid = 1'b1;
    wait_hs();
    data = 8'h22;
    wait_hs();
    data = 8'h33;
    last = 1'b1;
    repeat (48) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    valid = 1'b0;
    last  = 1'b0;
    #1;
    chk("midrst_txd", 32'(txd), 32'h1);
    chk("midrst_oe", 32'(oe), 32'h0);
    chk("midrst_active", 32'(active), 32'h0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    b = '{8'h00}; send_pkt(b, 0); drain();

    for (int p = 0; p < 20; p++) begin
      n = $urandom_range(1, 4);
      b.delete();
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) b.push_back(8'hFF);
        else b.push_back(8'($urandom()));
      end
      trunc = ($urandom_range(0, 5) == 0);
      send_pkt(b, trunc);
      if (!trunc && $urandom_range(0, 1) == 1) drain();
      repeat ($urandom_range(0, 40)) @(posedge clk);
      #1;
    end
    drain();
    repeat (40) @(posedge clk);
    chk("handshakes", 32'(hs_cnt), 32'(exp_hs));
    chk("errors", 32'(err_cnt), 32'(exp_err));
    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $finish;
  end

endmodule
